mem_bist_ctrl: RTL
==================

# mem_bist_ctrl

Hardware initiator for the `memory_wrapper` port set (`addr`, `wdata`, `wr_en`, `rd_en`, `rdata`). On a start pulse it writes a pseudo-random pattern to every address and reads every address back. Each returned word is compared against the regenerated pattern, and the block reports a pass/fail summary. It sits between the memory wrapper and system control, and replaces bench-driven frontdoor write/read sequences in silicon.

## Interface
- `width`, 8, bits per memory lane
- `depth`, 128, words per memory; must be ≥2 and ≤2^`addr_width`
- `addr_width`, 7, address bits
- `mem_number`, 4, lanes; total data width W = `width`*`mem_number`
- `RD_LAT`, 1, cycles from an `rd_en` cycle to valid `rdata`; must be ≥1
- `SEED`, 32'hACE10001, LFSR seed; must be nonzero
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `start` input 1: one-cycle request; sampled only in IDLE
- `addr` output `addr_width`: memory address
- `wdata` output W: write data
- `wr_en` output 1: write strobe
- `rd_en` output 1: read strobe
- `rdata` input W: read data from memory
- `busy` output 1: high from start accept until done
- `done` output 1: one-cycle completion pulse
- `pass` output 1: result; valid from `done`, held until next accepted start
- `err_count` output 16: mismatch count, saturates at 16'hFFFF
- `first_err_addr` output `addr_width`: address of first mismatch; 0 if none

## Operation
- All outputs are registered.
- Reset values: `addr`=0, `wdata`=0, `wr_en`=0, `rd_en`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0; FSM=IDLE.
- States: IDLE → WRITE → READ → DRAIN → DONE → IDLE.
- IDLE:
  - `start`=1 → WRITE.
  - On the accept edge: clear `err_count`, `first_err_addr`, `pass`; load LFSR with `SEED`; set `busy`.
- WRITE:
  - One word per cycle, addr k=0..`depth`-1, `wr_en`=1, `wdata`=P(k).
  - After `depth`-1 → READ with addr 0. No idle cycle between phases.
- READ:
  - `rd_en`=1, addr k=0..`depth`-1, one per cycle.
  - Expected P(k) is regenerated from `SEED` and delayed `RD_LAT` stages together with k.
- DRAIN: strobes low; lasts `RD_LAT`+1 cycles so the last compare completes.
- DONE:
  - `done`=1 for one cycle.
  - `pass`=1 iff `err_count`=0.
  - `busy` drops on the same edge that raises `done`.
- Pattern generation:
  - P(k) is the LFSR state after k steps from `SEED`.
  - Galois LFSR, 32 bit, taps 32'h80200003.
  - The 32-bit value is replicated ceil(W/32) times; the low W bits are used.
- Compare:
  - Any bit difference across all W bits counts as one error.
  - The first error latches `first_err_addr`; later errors do not change it.
  - `err_count` increments per mismatched word and saturates at 16'hFFFF.
- `start` while not IDLE is ignored. There is no queueing.
- `wr_en` and `rd_en` are never high in the same cycle.
- `rst` mid-operation returns every output to its reset value on that edge. No further strobes are issued, and any in-flight compares are discarded.

## Timing
- Edge E0 accepts `start`. Write k is driven after edge Ek, for k=0..`depth`-1.
- Read k is driven after edge E(`depth`+k).
- The compare for read k happens at edge E(`depth`+k+`RD_LAT`+1).
- `done` is high after edge E(2*`depth`+`RD_LAT`+1) for one cycle.
- Defaults (`depth`=128, `RD_LAT`=1): `done` at E258.
- Earliest next accepted `start` is at the edge ending the `done` cycle + 1, i.e. the cycle after `done`.

## Configuration
- `MEM_BIST_INV_PASS_EN` defined:
  - After the first DRAIN, the FSM runs a second WRITE/READ/DRAIN pass instead of going to DONE.
  - The second pass uses data ~P(k): same LFSR restarted from `SEED`, all W bits inverted.
  - Errors accumulate across both passes. `first_err_addr` is the earliest failure in time.
  - `done` is at E(4*`depth`+2*`RD_LAT`+2); E516 at defaults.
- Macro undefined: single pass only, with the timing given above.

## Test plan
- Ideal memory model (`RD_LAT`=1), `start` pulse at defaults:
  - 128 writes with `wdata`=P(k) exactly, then 128 reads.
  - `done` at E258, `pass`=1, `err_count`=0, `first_err_addr`=0.
- Model corrupts bit 0 on reads at addr 5 and addr 90 → `pass`=0, `err_count`=2, `first_err_addr`=5.
- `rst` asserted after 40 writes:
  - Next edge: all outputs 0, no more strobes.
  - A following `start` runs a clean full test with `pass`=1.
- `start` held high continuously:
  - Exactly one test per IDLE visit.
  - Second test accepted the cycle after `done`; pulses in WRITE/READ have no effect.
- `RD_LAT`=3 with a matching model → `pass`=1, `done` at E260. Model with 1 extra cycle of latency → `err_count`=128.
- `MEM_BIST_INV_PASS_EN` with a model whose bit 3 at addr 7 is stuck at 1:
  - Pass 1 passes if P(7) bit 3 is 1; pass 2 (~P, bit 3 = 0) fails.
  - Result `err_count`=1, `first_err_addr`=7, `done` at E516.

Source files
------------

// File: rtl/mem_bist_ctrl_if.sv
// Memory-wrapper port bundle between the BIST initiator and the memory.
// master drives address, write data and strobes; slave returns read data.
interface mem_bist_ctrl_if #(
    parameter int addr_width = 7,
    parameter int data_width = 32
);
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] wdata;
    logic                  wr_en;
    logic                  rd_en;
    logic [data_width-1:0] rdata;

    modport master (output addr, wdata, wr_en, rd_en, input rdata);
    modport slave  (input addr, wdata, wr_en, rd_en, output rdata);
endinterface

// File: rtl/mem_bist_ctrl.sv
// Memory BIST: writes an LFSR pattern to every address, reads back and compares; MEM_BIST_INV_PASS_EN adds an inverted-data pass.
// Latency: done 2*depth+RD_LAT+1 cycles after start accept (2*depth+RD_LAT+1 more with the inverted pass).
// Backpressure: none; memory takes one access per cycle, start is ignored unless idle.
module mem_bist_ctrl #(
    parameter int          width      = 8,
    parameter int          depth      = 128,
    parameter int          addr_width = 7,
    parameter int          mem_number = 4,
    parameter int          RD_LAT     = 1,
    parameter logic [31:0] SEED       = 32'hACE10001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    mem_bist_ctrl_if.master       mem,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [addr_width-1:0] first_err_addr
);
    localparam int                    W    = width * mem_number;
    localparam int                    REP  = (W + 31) / 32;
    localparam logic [31:0]           TAPS = 32'h80200003;
    localparam int                    CW   = $clog2(RD_LAT + 2);
    localparam logic [addr_width-1:0] LAST = addr_width'(depth - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [addr_width-1:0] addr_q, addr_nxt;
    logic [W-1:0]          wdata_q, wdata_nxt;
    logic                  wr_en_q, wr_en_nxt;
    logic                  rd_en_q, rd_en_nxt;
    logic                  busy_nxt, done_nxt, pass_nxt;
    logic [31:0]           lfsr, lfsr_nxt, pat_src;
    logic [W-1:0]          pat_word;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  inv, inv_nxt;
    logic                  clear;

    // Expected-data pipeline: stage 0 loads with the read strobe, compare uses stage RD_LAT.
    logic [W-1:0]          exp_dat  [RD_LAT+1];
    logic [addr_width-1:0] exp_addr [RD_LAT+1];
    logic [RD_LAT:0]       exp_vld;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    function automatic logic [W-1:0] expand(input logic [31:0] s, input logic iv);
        logic [REP*32-1:0] r;
        r = {REP{s}};
        return r[W-1:0] ^ {W{iv}};
    endfunction

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        wr_en_nxt = 1'b0;
        rd_en_nxt = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        pass_nxt  = pass;
        cnt_nxt   = cnt;
        inv_nxt   = inv;
        clear     = 1'b0;
        pat_src   = lfsr;
        case (state)
            IDLE: if (start) begin
                state_nxt = WRITE;
                clear     = 1'b1;
                busy_nxt  = 1'b1;
                pass_nxt  = 1'b0;
                inv_nxt   = 1'b0;
                addr_nxt  = '0;
                wr_en_nxt = 1'b1;
                pat_src   = SEED;
            end
            WRITE: if (addr_q == LAST) begin
                state_nxt = READ;
                addr_nxt  = '0;
                rd_en_nxt = 1'b1;
                pat_src   = SEED;
            end else begin
                addr_nxt  = addr_q + 1'b1;
                wr_en_nxt = 1'b1;
            end
            READ: if (addr_q == LAST) begin
                state_nxt = DRAIN;
                addr_nxt  = '0;
                cnt_nxt   = '0;
            end else begin
                addr_nxt  = addr_q + 1'b1;
                rd_en_nxt = 1'b1;
            end
            DRAIN: if (cnt == CW'(RD_LAT)) begin
`ifdef MEM_BIST_INV_PASS_EN
                if (!inv) begin
                    state_nxt = WRITE;
                    inv_nxt   = 1'b1;
                    wr_en_nxt = 1'b1;
                    pat_src   = SEED;
                end else begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_count == 16'h0);
                end
`else
                state_nxt = DONE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                pass_nxt  = (err_count == 16'h0);
`endif
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        lfsr_nxt  = (wr_en_nxt || rd_en_nxt) ? lfsr_step(pat_src) : lfsr;
        pat_word  = expand(pat_src, inv_nxt);
        wdata_nxt = wr_en_nxt ? pat_word : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            lfsr    <= SEED;
            cnt     <= '0;
            inv     <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            wr_en_q <= wr_en_nxt;
            rd_en_q <= rd_en_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            pass    <= pass_nxt;
            lfsr    <= lfsr_nxt;
            cnt     <= cnt_nxt;
            inv     <= inv_nxt;
        end
    end

    always_ff @(posedge clk) begin
        exp_dat[0]  <= pat_word;
        exp_addr[0] <= addr_nxt;
        for (int i = 1; i <= RD_LAT; i++) begin
            exp_dat[i]  <= exp_dat[i-1];
            exp_addr[i] <= exp_addr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_vld        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            exp_vld <= {exp_vld[RD_LAT-1:0], rd_en_nxt};
            if (clear) begin
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (exp_vld[RD_LAT] && (mem.rdata != exp_dat[RD_LAT])) begin
                if (err_count == 16'h0)
                    first_err_addr <= exp_addr[RD_LAT];
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
            end
        end
    end

    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;
    assign mem.wr_en = wr_en_q;
    assign mem.rd_en = rd_en_q;
endmodule
